// File: rtl/arb_wrr_pkg.sv
// Shared constants and state type for the weighted round-robin arbiter.
package arb_wrr_pkg;

    localparam int N      = 8;
    localparam int WW     = 4;
    localparam int IDW    = 3;
    localparam int WT_RST = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        REFILL = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Find-first-set over the eligibility vector, starting at ptr and wrapping 7->0.
module arb_rr_pick
    import arb_wrr_pkg::*;
(
    input  logic [N-1:0]   elig,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] idx
);

    // Walk the requesters in rotated order and keep the first eligible one.
    always_comb begin
        logic [IDW-1:0] w_pos;
        found = 1'b0;
        idx   = '0;
        w_pos = ptr;
        for (int k = 0; k < N; k++) begin
            w_pos = ptr + IDW'(k);
            if (!found && elig[w_pos]) begin
                found = 1'b1;
                idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/arbiter_8x8_wrr.sv
// Eight-requester weighted round-robin arbiter with grant hold until done.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no owner; pick an eligible requester or request a refill
// GRANT  | owner holds grant until it pulses done
// REFILL | reload every credit from its weight, then back to IDLE
module arbiter_8x8_wrr #(
    parameter int N  = 8,
    parameter int WW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          done,
    input  logic          wt_we,
    input  logic [2:0]    wt_idx,
    input  logic [WW-1:0] wt_data,
    output logic [N-1:0]  grant,
    output logic          grant_vld,
    output logic [2:0]    grant_id
);

    import arb_wrr_pkg::*;

    localparam logic [N-1:0]  GNT_ONE = N'(1);
    localparam logic [WW-1:0] CR_ONE  = WW'(1);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [N-1:0]  r_grant;
    logic [N-1:0]  w_grant_nxt;
    logic [2:0]    r_grant_id;
    logic [2:0]    w_id_nxt;
    logic [2:0]    r_ptr;
    logic [2:0]    w_ptr_nxt;
    logic [WW-1:0] r_weight [N];
    logic [WW-1:0] r_credit [N];
    logic [N-1:0]  w_elig;
    logic [N-1:0]  w_want;
    logic          w_found;
    logic [2:0]    w_pick_idx;
    logic          w_refill;
    logic          w_consume;
    logic [WW-1:0] w_cred_left;

    // A requester wants service if its weight is nonzero; it may be served if credit remains.
    always_comb begin
        w_elig = '0;
        w_want = '0;
        for (int i = 0; i < N; i++) begin
            w_want[i] = req[i] & (r_weight[i] != '0);
            w_elig[i] = w_want[i] & (r_credit[i] != '0);
        end
    end

    arb_rr_pick u_pick (
        .elig  (w_elig),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_pick_idx)
    );

    assign w_cred_left = r_credit[r_grant_id] - CR_ONE;

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_id_nxt    = r_grant_id;
        w_ptr_nxt   = r_ptr;
        w_refill    = 1'b0;
        w_consume   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_nxt = GNT_ONE << w_pick_idx;
                    w_id_nxt    = w_pick_idx;
                    w_state_nxt = GRANT;
                end else if (w_want != '0) begin
                    w_state_nxt = REFILL;
                end
            end
            GRANT: begin
                // Owner keeps the pointer while it still has credit and still requests.
                if (done) begin
                    w_grant_nxt = '0;
                    w_id_nxt    = '0;
                    w_consume   = 1'b1;
                    if ((w_cred_left == '0) || !req[r_grant_id]) begin
                        w_ptr_nxt = r_grant_id + 3'd1;
                    end else begin
                        w_ptr_nxt = r_grant_id;
                    end
                    w_state_nxt = IDLE;
                end
            end
            REFILL: begin
                w_refill    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_grant_nxt = '0;
                w_id_nxt    = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, pointer and registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_id_nxt;
            r_ptr      <= w_ptr_nxt;
        end
    end

    // Run-time weight programming; a refill in the same cycle still sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_weight[i] <= WW'(WT_RST);
            end
        end else if (wt_we) begin
            r_weight[wt_idx] <= wt_data;
        end
    end

    // Credits reload on refill and drop by one when the owner finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_credit[i] <= WW'(WT_RST);
            end
        end else if (w_refill) begin
            for (int i = 0; i < N; i++) begin
                r_credit[i] <= r_weight[i];
            end
        end else if (w_consume) begin
            r_credit[r_grant_id] <= w_cred_left;
        end
    end

    assign grant     = r_grant;
    assign grant_vld = |r_grant;
    assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_arbiter_8x8_wrr.sv
// Self-checking bench for arbiter_8x8_wrr against a transaction-level model.
module tb_arbiter_8x8_wrr;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       wt_we;
    logic [2:0] wt_idx;
    logic [3:0] wt_data;
    logic [7:0] grant;
    logic       grant_vld;
    logic [2:0] grant_id;

    int checks = 0;
    int errors = 0;

    // Model: weights, credits and round-robin pointer as plain integers.
    int m_w [8];
    int m_c [8];
    int m_ptr;

    arbiter_8x8_wrr #(.N(8), .WW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .wt_we     (wt_we),
        .wt_idx    (wt_idx),
        .wt_data   (wt_data),
        .grant     (grant),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void m_reset();
        for (int i = 0; i < 8; i++) begin
            m_w[i] = 1;
            m_c[i] = 1;
        end
        m_ptr = 0;
    endfunction

    // Returns the next owner for request vector r, or -1 if nobody will be served.
    function automatic int m_pick(input logic [7:0] r, output bit refill);
        bit any_elig;
        bit any_want;
        int j;
        any_elig = 0;
        any_want = 0;
        refill   = 0;
        for (int i = 0; i < 8; i++) begin
            if (r[i] && m_w[i] != 0) begin
                any_want = 1;
                if (m_c[i] != 0) any_elig = 1;
            end
        end
        if (!any_elig) begin
            if (!any_want) return -1;
            refill = 1;
            for (int i = 0; i < 8; i++) m_c[i] = m_w[i];
        end
        for (int k = 0; k < 8; k++) begin
            j = (m_ptr + k) % 8;
            if (r[j] && m_w[j] != 0 && m_c[j] != 0) return j;
        end
        return -1;
    endfunction

    task automatic idle_write(input logic [2:0] idx, input logic [3:0] data);
        req     = 8'h00;
        wt_we   = 1'b1;
        wt_idx  = idx;
        wt_data = data;
        @(negedge clk);
        wt_we   = 1'b0;
        m_w[idx] = int'(data);
    endtask

    // One transaction: request, expected grant and latency, hold, done, release.
    task automatic do_txn(input logic [7:0] r, input int hold, input logic [7:0] r_late,
                          input int late_at, input int done_len, input bit wr_en,
                          input logic [2:0] wr_idx, input logic [3:0] wr_data,
                          input bit co_wr, output int gid);
        int e_id;
        int lat;
        int e_lat;
        bit refill;
        logic [7:0] e_g;
        logic [3:0] co_data;
        req  = r;
        e_id = m_pick(r, refill);
        if (e_id < 0) begin
            repeat (3) begin
                @(negedge clk);
                checks++;
                if (grant !== 8'h00) begin
                    errors++;
                    $display("FAIL idle_no_grant: grant=%h required=00 req=%h", grant, r);
                end
            end
            gid = -1;
            return;
        end
        e_g   = 8'h01 << e_id;
        e_lat = refill ? 3 : 1;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (grant_vld !== 1'b1 && lat < 8);
        checks++;
        if (lat != e_lat) begin
            errors++;
            $display("FAIL grant_latency: got %0d cycles required %0d (req=%h)", lat, e_lat, r);
        end
        checks++;
        if (grant !== e_g || grant_id !== e_id[2:0]) begin
            errors++;
            $display("FAIL grant_pick: grant=%h id=%0d required grant=%h id=%0d", grant, grant_id, e_g, e_id);
        end
        for (int h = 0; h < hold; h++) begin
            wt_we = 1'b0;
            if (h == late_at) req = r_late;
            if (wr_en && h == 0) begin
                wt_we   = 1'b1;
                wt_idx  = wr_idx;
                wt_data = wr_data;
            end
            @(negedge clk);
            if (wr_en && h == 0) m_w[wr_idx] = int'(wr_data);
            checks++;
            if (grant !== e_g || grant_id !== e_id[2:0]) begin
                errors++;
                $display("FAIL hold_grant: grant=%h id=%0d required grant=%h id=%0d", grant, grant_id, e_g, e_id);
            end
        end
        wt_we = 1'b0;
        done  = 1'b1;
        if (co_wr) begin
            co_data = 4'($urandom_range(0, 15));
            wt_we   = 1'b1;
            wt_idx  = e_id[2:0];
            wt_data = co_data;
            m_w[e_id] = int'(co_data);
        end
        m_c[e_id] = m_c[e_id] - 1;
        m_ptr = (m_c[e_id] == 0 || !req[e_id]) ? (e_id + 1) % 8 : e_id;
        @(negedge clk);
        wt_we = 1'b0;
        done  = (done_len > 1);
        checks++;
        if (grant !== 8'h00 || grant_vld !== 1'b0 || grant_id !== 3'd0) begin
            errors++;
            $display("FAIL release: grant=%h vld=%b id=%0d required 00/0/0", grant, grant_vld, grant_id);
        end
        if (done_len > 1) begin
            req = 8'h00;
            @(negedge clk);
            done = 1'b0;
            checks++;
            if (grant !== 8'h00) begin
                errors++;
                $display("FAIL done_once: grant=%h required=00", grant);
            end
        end
        gid = e_id;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        req     = 8'h00;
        done    = 1'b0;
        wt_we   = 1'b0;
        wt_idx  = 3'd0;
        wt_data = 4'd0;
        m_reset();
        #1;
        checks++;
        if (grant !== 8'h00 || grant_vld !== 1'b0 || grant_id !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: grant=%h vld=%b id=%0d required 00/0/0", grant, grant_vld, grant_id);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int gid;
        for (int i = 0; i < 9; i++) begin
            do_txn(8'hFF, 1, 8'hFF, 99, 1, 0, 3'd0, 4'd0, 0, gid);
            checks++;
            if (gid != i % 8) begin
                errors++;
                $display("FAIL rr_order: step %0d got id %0d required %0d", i, gid, i % 8);
            end
        end
    endtask

    task automatic test_weighted();
        int gid;
        for (int i = 0; i < 8; i++) begin
            idle_write(3'(i), (i == 2) ? 4'd3 : (i == 5) ? 4'd1 : 4'd0);
        end
        for (int i = 0; i < 9; i++) begin
            do_txn(8'h24, $urandom_range(0, 3), 8'h24, 99, 1, 0, 3'd0, 4'd0, 0, gid);
            checks++;
            if (gid != 2 && gid != 5) begin
                errors++;
                $display("FAIL weighted_id: got %0d required 2 or 5", gid);
            end
        end
    endtask

    task automatic test_hold();
        int gid;
        for (int i = 0; i < 8; i++) idle_write(3'(i), 4'd1);
        do_txn(8'h08, 10, 8'h00, 2, 1, 0, 3'd0, 4'd0, 0, gid);
        checks++;
        if (gid != 3) begin
            errors++;
            $display("FAIL hold_owner: got %0d required 3", gid);
        end
        do_txn(8'h18, 1, 8'h18, 99, 2, 0, 3'd0, 4'd0, 0, gid);
        checks++;
        if (gid != 4) begin
            errors++;
            $display("FAIL hold_ptr_next: got %0d required 4", gid);
        end
    endtask

    task automatic test_zero_owner();
        int gid;
        do_txn(8'h02, 4, 8'h02, 99, 1, 1, 3'd1, 4'd0, 0, gid);
        checks++;
        if (gid != 1) begin
            errors++;
            $display("FAIL zero_owner_kept: got %0d required 1", gid);
        end
        for (int i = 0; i < 4; i++) begin
            do_txn(8'h03, 1, 8'h03, 99, 1, 0, 3'd0, 4'd0, 0, gid);
            checks++;
            if (gid != 0) begin
                errors++;
                $display("FAIL zero_weight_skip: got %0d required 0", gid);
            end
        end
    endtask

    task automatic test_wrap();
        int gid;
        idle_write(3'd1, 4'd1);
        do_txn(8'h80, 1, 8'h80, 99, 1, 0, 3'd0, 4'd0, 0, gid);
        checks++;
        if (gid != 7) begin
            errors++;
            $display("FAIL wrap_first: got %0d required 7", gid);
        end
        do_txn(8'h81, 1, 8'h81, 99, 1, 0, 3'd0, 4'd0, 0, gid);
        checks++;
        if (gid != 0) begin
            errors++;
            $display("FAIL wrap_next: got %0d required 0", gid);
        end
    endtask

    task automatic test_random();
        int gid;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                idle_write(3'($urandom_range(0, 7)), 4'($urandom_range(0, 4)));
            end
            do_txn(8'($urandom), $urandom_range(0, 4), 8'($urandom), $urandom_range(0, 4),
                   $urandom_range(1, 2), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   4'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0), gid);
        end
    endtask

    task automatic test_reset_mid();
        int gid;
        int n;
        req = 8'hFF;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant_vld !== 1'b1 && n < 8);
        checks++;
        if (grant_vld !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_setup: vld=%b required 1", grant_vld);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 8'h00 || grant_vld !== 1'b0 || grant_id !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset_async: grant=%h vld=%b id=%0d required 00/0/0", grant, grant_vld, grant_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        do_txn(8'hFF, 1, 8'hFF, 99, 1, 0, 3'd0, 4'd0, 0, gid);
        checks++;
        if (gid != 0) begin
            errors++;
            $display("FAIL mid_reset_first: got %0d required 0", gid);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_weighted();
        test_hold();
        test_zero_owner();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
